// File: rtl/i2c_slave.sv
// I2C target at a fixed 7-bit address, storing written bytes into a 16-byte register file.
// Define I2C_SLAVE_READ_EN to add the master-read path (bytes shifted out from index 0).
module i2c_slave #(
    parameter logic [6:0] ADDR = 7'h21
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         scl_in,
    input  logic         sda_in,
    output logic         sda_oe,
    output logic [127:0] data,
    output logic [7:0]   rx_byte,
    output logic         rx_valid,
    output logic [4:0]   rx_count,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT_STOP
    } state_t;

    state_t       state, state_nxt;
    logic [2:0]   scl_sync, sda_sync;
    logic         scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]   bit_cnt, bit_cnt_nxt;
    logic [7:0]   shreg, shreg_nxt, byte_in;
    logic         addr_hit;
    logic         sda_oe_nxt, busy_nxt, rx_valid_nxt;
    logic [7:0]   rx_byte_nxt;
    logic [4:0]   rx_count_nxt;
    logic [127:0] data_nxt;
`ifdef I2C_SLAVE_READ_EN
    logic         rw, rw_nxt;
    logic [3:0]   rd_idx, rd_idx_nxt;
    logic [7:0]   rd_cur;
`endif

    // [0],[1] are the two synchronizer flops, [2] is the history sample
    assign scl_rise  =  scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] &  scl_sync[2];
    assign start_det =  scl_sync[1] &  scl_sync[2] &  sda_sync[2] & ~sda_sync[1];
    assign stop_det  =  scl_sync[1] &  scl_sync[2] & ~sda_sync[2] &  sda_sync[1];

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        sda_oe_nxt   = sda_oe;
        busy_nxt     = busy;
        rx_byte_nxt  = rx_byte;
        rx_valid_nxt = 1'b0;
        rx_count_nxt = rx_count;
        data_nxt     = data;
`ifdef I2C_SLAVE_READ_EN
        rw_nxt       = rw;
        rd_idx_nxt   = rd_idx;
        rd_cur       = data[{rd_idx, 3'b000} +: 8];
`endif
        byte_in      = {shreg[6:0], sda_sync[1]};
        addr_hit     = (byte_in[7:1] == ADDR);

        if (start_det) begin
            state_nxt   = S_ADDR;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
`ifdef I2C_SLAVE_READ_EN
            rd_idx_nxt  = '0;
`endif
        end else if (stop_det) begin
            state_nxt  = S_IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else begin
            case (state)
                S_ADDR: if (scl_rise) begin
                    shreg_nxt   = byte_in;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
`ifdef I2C_SLAVE_READ_EN
                        if (addr_hit) begin
                            rw_nxt = byte_in[0];
`else
                        if (addr_hit && !byte_in[0]) begin
`endif
                            state_nxt = S_ADDR_ACK;
                            busy_nxt  = 1'b1;
                            if (!byte_in[0])
                                rx_count_nxt = '0;
                        end else begin
                            state_nxt = S_WAIT_STOP;
                        end
                    end
                end
                // sda_oe doubles as the ACK phase marker: first fall drives, second releases
                S_ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_nxt = 1'b1;
                    end else begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = '0;
                        state_nxt   = S_WRITE;
`ifdef I2C_SLAVE_READ_EN
                        if (rw) begin
                            state_nxt  = S_READ;
                            sda_oe_nxt = ~rd_cur[7];
                            shreg_nxt  = {rd_cur[6:0], 1'b0};
                            rd_idx_nxt = rd_idx + 4'd1;
                        end
`endif
                    end
                end
                S_WRITE: if (scl_rise) begin
                    shreg_nxt   = byte_in;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        if (rx_count[4]) begin
                            state_nxt = S_WAIT_STOP;
                        end else begin
                            data_nxt[{rx_count[3:0], 3'b000} +: 8] = byte_in;
                            rx_count_nxt = rx_count + 5'd1;
                            rx_byte_nxt  = byte_in;
                            rx_valid_nxt = 1'b1;
                            state_nxt    = S_WRITE_ACK;
                        end
                    end
                end
                S_WRITE_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_nxt = 1'b1;
                    end else begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = '0;
                        state_nxt   = S_WRITE;
                    end
                end
`ifdef I2C_SLAVE_READ_EN
                S_READ: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_nxt  = S_READ_ACK;
                            sda_oe_nxt = 1'b0;
                        end else begin
                            sda_oe_nxt = ~shreg[7];
                            shreg_nxt  = {shreg[6:0], 1'b0};
                        end
                    end
                end
                S_READ_ACK: begin
                    if (scl_rise && sda_sync[1]) begin
                        state_nxt = S_WAIT_STOP;
                    end else if (scl_fall) begin
                        state_nxt   = S_READ;
                        sda_oe_nxt  = ~rd_cur[7];
                        shreg_nxt   = {rd_cur[6:0], 1'b0};
                        bit_cnt_nxt = '0;
                        rd_idx_nxt  = rd_idx + 4'd1;
                    end
                end
`endif
                default: ;
            endcase
        end

        if (state_nxt == S_IDLE || state_nxt == S_WAIT_STOP)
            sda_oe_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
            bit_cnt  <= '0;
            shreg    <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_count <= '0;
            data     <= '0;
`ifdef I2C_SLAVE_READ_EN
            rw       <= 1'b0;
            rd_idx   <= '0;
`endif
        end else begin
            state    <= state_nxt;
            scl_sync <= {scl_sync[1:0], scl_in};
            sda_sync <= {sda_sync[1:0], sda_in};
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            sda_oe   <= sda_oe_nxt;
            busy     <= busy_nxt;
            rx_byte  <= rx_byte_nxt;
            rx_valid <= rx_valid_nxt;
            rx_count <= rx_count_nxt;
            data     <= data_nxt;
`ifdef I2C_SLAVE_READ_EN
            rw       <= rw_nxt;
            rd_idx   <= rd_idx_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, write vector table plus hand-written corner sequences.
module tb_i2c_slave;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         scl = 1'b1;
    logic         sda_m = 1'b1;
    logic         sda_bus;
    logic         sda_oe;
    logic [127:0] data;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic [4:0]   rx_count;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;
    int oe_cycles = 0;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave #(.ADDR(7'h21)) dut (
        .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
        .data(data), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_count(rx_count), .busy(busy)
    );

    always @(posedge clk) begin
        if (rx_valid === 1'b1) pulses <= pulses + 1;
        if (sda_oe === 1'b1) oe_cycles <= oe_cycles + 1;
    end

    typedef struct {
        logic [7:0]  addr;
        int          n;
        logic [31:0] b;
        logic        exp_ack;
        logic [4:0]  exp_cnt;
        logic [31:0] exp_lo;
        logic [7:0]  exp_rx;
    } wvec_t;

    wvec_t vec [4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic q();
        repeat (8) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; q(); scl = 1'b1; q(); sda_m = 1'b0; q(); scl = 1'b0; q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; q(); scl = 1'b1; q(); sda_m = 1'b1; q();
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_m = b; q(); scl = 1'b1; q(); s = sda_bus; q(); scl = 1'b0; q();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            b[i] = s;
        end
        bus_bit(~mack, s);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic         ack, s;
        logic [7:0]   rb;
        logic [127:0] exp_d;
        int           p0, o0;

        vec[0] = '{addr:8'h42, n:2, b:32'h0000F0A0, exp_ack:1'b1, exp_cnt:5'd2, exp_lo:32'h0000F0A0, exp_rx:8'hF0};
        vec[1] = '{addr:8'h44, n:1, b:32'h00000055, exp_ack:1'b0, exp_cnt:5'd2, exp_lo:32'h0000F0A0, exp_rx:8'hF0};
        vec[2] = '{addr:8'h42, n:3, b:32'h00332211, exp_ack:1'b1, exp_cnt:5'd3, exp_lo:32'h00332211, exp_rx:8'h33};
        vec[3] = '{addr:8'hA2, n:2, b:32'h0000BEEF, exp_ack:1'b0, exp_cnt:5'd3, exp_lo:32'h00332211, exp_rx:8'h33};

        repeat (3) @(negedge clk);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_byte", rx_byte, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_data", data, 0);
        reset = 1'b1;
        q();

        for (int v = 0; v < 4; v++) begin
            p0 = pulses; o0 = oe_cycles;
            bus_start();
            wr_byte(vec[v].addr, ack);
            chk($sformatf("v%0d_addr_ack", v), ack, vec[v].exp_ack);
            chk($sformatf("v%0d_busy_mid", v), busy, vec[v].exp_ack);
            for (int j = 0; j < vec[v].n; j++) begin
                wr_byte(vec[v].b[j*8 +: 8], ack);
                chk($sformatf("v%0d_byte%0d_ack", v, j), ack, vec[v].exp_ack);
            end
            bus_stop(); q();
            chk($sformatf("v%0d_busy_end", v), busy, 0);
            chk($sformatf("v%0d_sda_oe_end", v), sda_oe, 0);
            chk($sformatf("v%0d_rx_count", v), rx_count, vec[v].exp_cnt);
            chk($sformatf("v%0d_data", v), data, {96'h0, vec[v].exp_lo});
            chk($sformatf("v%0d_rx_byte", v), rx_byte, vec[v].exp_rx);
            chk($sformatf("v%0d_pulses", v), pulses - p0, vec[v].exp_ack ? vec[v].n : 0);
            if (!vec[v].exp_ack)
                chk($sformatf("v%0d_oe_never", v), oe_cycles - o0, 0);
        end

        // 17 bytes: the 17th must be refused and not stored
        p0 = pulses;
        exp_d = '0;
        bus_start();
        wr_byte(8'h42, ack);
        chk("ovf_addr_ack", ack, 1);
        for (int k = 0; k < 17; k++) begin
            wr_byte(8'(k), ack);
            chk($sformatf("ovf_byte%0d_ack", k), ack, (k < 16) ? 1 : 0);
            if (k < 16) exp_d[k*8 +: 8] = 8'(k);
        end
        bus_stop(); q();
        chk("ovf_rx_count", rx_count, 16);
        chk("ovf_data", data, exp_d);
        chk("ovf_pulses", pulses - p0, 16);
        chk("ovf_rx_byte", rx_byte, 8'h0F);
        chk("ovf_busy_end", busy, 0);

        // reset during the 4th data bit of byte 0x5A
        bus_start();
        wr_byte(8'h42, ack);
        chk("rst_mid_addr_ack", ack, 1);
        bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b0, s);
        sda_m = 1'b1; q();
        reset = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_mid_sda_oe", sda_oe, 0);
        chk("rst_mid_data", data, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rx_count", rx_count, 0);
        reset = 1'b1;
        scl = 1'b1; q(); q(); scl = 1'b0; q();
        bus_stop(); q();

        bus_start();
        wr_byte(8'h42, ack);
        chk("post_rst_addr_ack", ack, 1);
        wr_byte(8'hA0, ack);
        chk("post_rst_b0_ack", ack, 1);
        wr_byte(8'hF0, ack);
        chk("post_rst_b1_ack", ack, 1);
        bus_stop(); q();
        chk("post_rst_data", data, 128'hF0A0);
        chk("post_rst_rx_count", rx_count, 2);
        chk("post_rst_busy", busy, 0);

        // master read of three bytes, NACK on the last
        o0 = oe_cycles;
        bus_start();
        wr_byte(8'h43, ack);
`ifdef I2C_SLAVE_READ_EN
        chk("rd_addr_ack", ack, 1);
        rd_byte(1'b1, rb); chk("rd_byte0", rb, 8'hA0);
        rd_byte(1'b1, rb); chk("rd_byte1", rb, 8'hF0);
        rd_byte(1'b0, rb); chk("rd_byte2", rb, 8'h00);
        q();
        chk("rd_released", sda_oe, 0);
        chk("rd_busy_mid", busy, 1);
`else
        chk("rd_addr_nack", ack, 0);
        chk("rd_oe_never", oe_cycles - o0, 0);
`endif
        bus_stop(); q();
        chk("rd_busy_end", busy, 0);
        chk("rd_sda_oe_end", sda_oe, 0);

        // write one byte, repeated START, then read from index 0
        bus_start();
        wr_byte(8'h42, ack);
        chk("rs_addr_ack", ack, 1);
        wr_byte(8'h77, ack);
        chk("rs_byte_ack", ack, 1);
        bus_start();
        wr_byte(8'h43, ack);
`ifdef I2C_SLAVE_READ_EN
        chk("rs_rd_addr_ack", ack, 1);
        rd_byte(1'b0, rb);
        chk("rs_rd_byte0", rb, 8'h77);
`else
        chk("rs_rd_addr_nack", ack, 0);
`endif
        bus_stop(); q();
        chk("rs_data", data, 128'hF077);
        chk("rs_rx_count", rx_count, 1);
        chk("rs_busy_end", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
